// File: rtl/schmidl_cox_frame_gate_pkg.sv
// rtl/schmidl_cox_frame_gate_pkg.sv - register offsets, mode bits and FSM states for the frame gate
package schmidl_cox_frame_gate_pkg;

  localparam int SR_FRAME_LEN   = 0;
  localparam int SR_GAP_LEN     = 1;
  localparam int SR_OFFSET      = 2;
  localparam int SR_NUM_SYMBOLS = 3;
  localparam int SR_MODE        = 4;

  localparam int MODE_KEEP_CP     = 0;
  localparam int MODE_FRAME_TLAST = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFSET,
    ST_GAP,
    ST_SYMBOL
  } state_t;

endpackage

// File: rtl/schmidl_cox_frame_gate_setting_reg.sv
// rtl/schmidl_cox_frame_gate_setting_reg.sv - one settings-bus register with reset value
module schmidl_cox_frame_gate_setting_reg #(
  parameter int ADDR  = 0,
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe,
  input  logic [7:0]       addr,
  input  logic [31:0]      data,
  output logic [WIDTH-1:0] value
);

  logic [31:0] unused_data;
  assign unused_data = data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= AT_RESET;
    else if (strobe && addr == ADDR[7:0])
      value <= data[WIDTH-1:0];
  end

endmodule

// File: rtl/schmidl_cox_frame_gate.sv
// rtl/schmidl_cox_frame_gate.sv - trigger-started OFDM frame extractor with CP drop/keep and framing
module schmidl_cox_frame_gate
  import schmidl_cox_frame_gate_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int CNT_W         = 16,
  parameter int SR_BASE       = 129,
  parameter int DEF_FRAME_LEN = 64,
  parameter int DEF_GAP_LEN   = 16,
  parameter int DEF_NUM_SYM   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  input  logic             i_trig,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             sof,
  output logic             eof,
  output logic [CNT_W-1:0] trig_ignored
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] live_fl, live_gl, live_off, live_num;
  logic [1:0]       live_mode;
  logic [CNT_W-1:0] sh_fl, sh_gl, sh_off, sh_num;
  logic [1:0]       sh_mode;
  logic [CNT_W-1:0] stage_cnt, sym_cnt;
  logic             sof_pending;
  state_t           state;
  logic             unused_tlast;

  assign unused_tlast = i_tlast;

  schmidl_cox_frame_gate_setting_reg #(.ADDR(SR_BASE + SR_FRAME_LEN), .WIDTH(CNT_W),
    .AT_RESET(CNT_W'(DEF_FRAME_LEN))) u_sr_fl (.clk(clk), .rst(reset), .strobe(set_stb),
    .addr(set_addr), .data(set_data), .value(live_fl));
  schmidl_cox_frame_gate_setting_reg #(.ADDR(SR_BASE + SR_GAP_LEN), .WIDTH(CNT_W),
    .AT_RESET(CNT_W'(DEF_GAP_LEN))) u_sr_gl (.clk(clk), .rst(reset), .strobe(set_stb),
    .addr(set_addr), .data(set_data), .value(live_gl));
  schmidl_cox_frame_gate_setting_reg #(.ADDR(SR_BASE + SR_OFFSET), .WIDTH(CNT_W),
    .AT_RESET('0)) u_sr_off (.clk(clk), .rst(reset), .strobe(set_stb),
    .addr(set_addr), .data(set_data), .value(live_off));
  schmidl_cox_frame_gate_setting_reg #(.ADDR(SR_BASE + SR_NUM_SYMBOLS), .WIDTH(CNT_W),
    .AT_RESET(CNT_W'(DEF_NUM_SYM))) u_sr_num (.clk(clk), .rst(reset), .strobe(set_stb),
    .addr(set_addr), .data(set_data), .value(live_num));
  schmidl_cox_frame_gate_setting_reg #(.ADDR(SR_BASE + SR_MODE), .WIDTH(2),
    .AT_RESET('0)) u_sr_mode (.clk(clk), .rst(reset), .strobe(set_stb),
    .addr(set_addr), .data(set_data), .value(live_mode));

  logic passing, beat, sym_end, frame_end;

  // Pass-through with no storage: handshakes are steered purely by the current stage.
  assign passing   = (state == ST_SYMBOL) || (state == ST_GAP && sh_mode[MODE_KEEP_CP]);
  assign i_tready  = passing ? o_tready : 1'b1;
  assign o_tvalid  = passing && i_tvalid;
  assign o_tdata   = i_tdata;
  assign beat      = i_tvalid && i_tready;
  assign sym_end   = (state == ST_SYMBOL) && (stage_cnt == sh_fl - CNT_ONE);
  assign frame_end = sym_end && (sym_cnt == sh_num - CNT_ONE);
  assign o_tlast   = sh_mode[MODE_FRAME_TLAST] ? frame_end : sym_end;
  assign eof       = frame_end;
  assign sof       = passing && sof_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      stage_cnt    <= '0;
      sym_cnt      <= '0;
      sof_pending  <= 1'b0;
      trig_ignored <= '0;
      sh_fl        <= '0;
      sh_gl        <= '0;
      sh_off       <= '0;
      sh_num       <= '0;
      sh_mode      <= '0;
    end else if (clear) begin
      state        <= ST_IDLE;
      stage_cnt    <= '0;
      sym_cnt      <= '0;
      sof_pending  <= 1'b0;
      trig_ignored <= '0;
    end else if (beat) begin
      if (i_trig && state != ST_IDLE && trig_ignored != '1)
        trig_ignored <= trig_ignored + CNT_ONE;
      if (passing)
        sof_pending <= 1'b0;
      case (state)
        ST_IDLE: if (i_trig) begin
          sh_fl       <= (live_fl == '0) ? CNT_ONE : live_fl;
          sh_num      <= (live_num == '0) ? CNT_ONE : live_num;
          sh_gl       <= live_gl;
          sh_off      <= live_off;
          sh_mode     <= live_mode;
          stage_cnt   <= '0;
          sym_cnt     <= '0;
          sof_pending <= 1'b1;
          state <= (live_off != '0) ? ST_OFFSET : (live_gl != '0) ? ST_GAP : ST_SYMBOL;
        end
        ST_OFFSET: if (stage_cnt == sh_off - CNT_ONE) begin
          stage_cnt <= '0;
          state     <= (sh_gl != '0) ? ST_GAP : ST_SYMBOL;
        end else begin
          stage_cnt <= stage_cnt + CNT_ONE;
        end
        ST_GAP: if (stage_cnt == sh_gl - CNT_ONE) begin
          stage_cnt <= '0;
          state     <= ST_SYMBOL;
        end else begin
          stage_cnt <= stage_cnt + CNT_ONE;
        end
        ST_SYMBOL: if (frame_end) begin
          stage_cnt <= '0;
          sym_cnt   <= '0;
          state     <= ST_IDLE;
        end else if (sym_end) begin
          stage_cnt <= '0;
          sym_cnt   <= sym_cnt + CNT_ONE;
          state     <= (sh_gl != '0) ? ST_GAP : ST_SYMBOL;
        end else begin
          stage_cnt <= stage_cnt + CNT_ONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_schmidl_cox_frame_gate.sv
// tb/tb_schmidl_cox_frame_gate.sv - randomized lockstep bench against a positional frame model
module tb_schmidl_cox_frame_gate;

  logic        clk = 1'b0;
  logic        rst, clear, set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata, o_tdata;
  logic        i_tlast, i_tvalid, i_tready, i_trig;
  logic        o_tlast, o_tvalid, o_tready, sof, eof;
  logic [15:0] trig_ignored;

  schmidl_cox_frame_gate dut (
    .clk(clk), .reset(rst), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
    .i_tready(i_tready), .i_trig(i_trig), .o_tdata(o_tdata), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .sof(sof), .eof(eof),
    .trig_ignored(trig_ignored)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // live and frame-latched settings, position of the next beat inside the frame
  int l_fl, l_gl, l_off, l_num, l_mode;
  int m_fl, m_gl, m_off, m_num, m_mode;
  bit m_active;
  int m_p, m_ign;
  int sample_idx;
  int trig_q[$];
  int out_cnt, first_out, last_out, tlast_cnt, sof_cnt, eof_cnt, sof_pos, eof_pos;

  task automatic model_reset();
    l_fl = 64; l_gl = 16; l_off = 0; l_num = 1; l_mode = 0;
    m_active = 0; m_p = 0; m_ign = 0;
  endtask

  task automatic reset_stats();
    out_cnt = 0; first_out = -1; last_out = -1; tlast_cnt = 0;
    sof_cnt = 0; eof_cnt = 0; sof_pos = 0; eof_pos = 0;
  endtask

  task automatic step(input bit v, input bit otr, input bit clr);
    bit passing, lastsym, fin, sofx, exp_rdy, beat, trig_now;
    int q, len, r, sym;
    i_tvalid = v; o_tready = otr; clear = clr;
    trig_now = v && trig_q.size() > 0 && trig_q[0] == sample_idx;
    i_trig = trig_now;
    i_tdata = v ? 32'(sample_idx) : $urandom;
    i_tlast = 1'($urandom);
    passing = 0; lastsym = 0; fin = 0; sofx = 0;
    if (m_active && m_p >= m_off) begin
      q = m_p - m_off; len = m_gl + m_fl; sym = q / len; r = q % len;
      passing = (r >= m_gl) || ((m_mode & 1) != 0);
      lastsym = (r == len - 1);
      fin = lastsym && (sym == m_num - 1);
      sofx = passing && (q == (((m_mode & 1) != 0) ? 0 : m_gl));
    end
    exp_rdy = passing ? otr : 1'b1;
    @(negedge clk);
    total++; if (i_tready !== exp_rdy) begin bad++; $display("FAIL i_tready: got %b exp %b at sample %0d", i_tready, exp_rdy, sample_idx); end
    total++; if (o_tvalid !== (passing && v)) begin bad++; $display("FAIL o_tvalid: got %b exp %b at sample %0d", o_tvalid, passing && v, sample_idx); end
    total++; if (o_tdata !== i_tdata) begin bad++; $display("FAIL o_tdata: got %h exp %h", o_tdata, i_tdata); end
    total++; if (o_tlast !== (passing && (((m_mode & 2) != 0) ? fin : lastsym))) begin bad++; $display("FAIL o_tlast: got %b at sample %0d", o_tlast, sample_idx); end
    total++; if (sof !== sofx) begin bad++; $display("FAIL sof: got %b exp %b at sample %0d", sof, sofx, sample_idx); end
    total++; if (eof !== fin) begin bad++; $display("FAIL eof: got %b exp %b at sample %0d", eof, fin, sample_idx); end
    total++; if (trig_ignored !== 16'(m_ign)) begin bad++; $display("FAIL trig_ignored: got %0d exp %0d", trig_ignored, m_ign); end
    if (o_tvalid && o_tready) begin
      out_cnt++;
      if (out_cnt == 1) first_out = int'(o_tdata);
      last_out = int'(o_tdata);
      if (o_tlast) tlast_cnt++;
      if (sof) begin sof_cnt++; sof_pos = out_cnt; end
      if (eof) begin eof_cnt++; eof_pos = out_cnt; end
    end
    beat = v && exp_rdy;
    @(posedge clk);
    if (clr) begin
      m_active = 0; m_ign = 0;
    end else if (beat) begin
      if (m_active) begin
        if (trig_now && m_ign < 65535) m_ign++;
        m_p++;
        if (m_p == m_off + m_num * (m_gl + m_fl)) m_active = 0;
      end else if (trig_now) begin
        m_fl = (l_fl == 0) ? 1 : l_fl; m_num = (l_num == 0) ? 1 : l_num;
        m_gl = l_gl; m_off = l_off; m_mode = l_mode;
        m_active = 1; m_p = 0;
      end
    end
    if (beat) begin
      if (trig_now) void'(trig_q.pop_front());
      sample_idx++;
    end
    if (set_stb) begin
      case (int'(set_addr) - 129)
        0: l_fl = int'(set_data[15:0]);
        1: l_gl = int'(set_data[15:0]);
        2: l_off = int'(set_data[15:0]);
        3: l_num = int'(set_data[15:0]);
        4: l_mode = int'(set_data[1:0]);
        default: ;
      endcase
    end
    #1;
    set_stb = 0;
  endtask

  task automatic write_set(input int off, input int data);
    set_stb = 1; set_addr = 8'(129 + off); set_data = 32'(data);
    step(0, 1, 0);
  endtask

  task automatic configure(input int fl, input int gl, input int off, input int num, input int mode);
    write_set(0, fl); write_set(1, gl); write_set(2, off); write_set(3, num); write_set(4, mode);
  endtask

  task automatic run(input int n, input int vpct, input int rpct);
    for (int i = 0; i < n; i++)
      step($urandom_range(99) < vpct, $urandom_range(99) < rpct, 0);
  endtask

  task automatic test_reset();
    total++; if (o_tvalid !== 1'b0) begin bad++; $display("FAIL reset o_tvalid: got %b exp 0", o_tvalid); end
    total++; if (i_tready !== 1'b1) begin bad++; $display("FAIL reset i_tready: got %b exp 1", i_tready); end
    total++; if ({o_tlast, sof, eof} !== 3'b000) begin bad++; $display("FAIL reset flags: got %b exp 000", {o_tlast, sof, eof}); end
    total++; if (trig_ignored !== 16'd0) begin bad++; $display("FAIL reset trig_ignored: got %0d exp 0", trig_ignored); end
  endtask

  task automatic test_single_frame();
    configure(64, 16, 0, 1, 0);
    reset_stats(); trig_q.push_back(100);
    run(220, 100, 100);
    total++; if (out_cnt != 64) begin bad++; $display("FAIL single count: got %0d exp 64", out_cnt); end
    total++; if (first_out != 117 || last_out != 180) begin bad++; $display("FAIL single range: got %0d..%0d exp 117..180", first_out, last_out); end
    total++; if (tlast_cnt != 1 || sof_cnt != 1 || eof_cnt != 1) begin bad++; $display("FAIL single flags: got tlast=%0d sof=%0d eof=%0d exp 1 1 1", tlast_cnt, sof_cnt, eof_cnt); end
    total++; if (trig_ignored !== 16'd0) begin bad++; $display("FAIL single ignored: got %0d exp 0", trig_ignored); end
  endtask

  task automatic test_multi_symbol();
    int tr;
    configure(64, 16, 0, 3, 0);
    reset_stats(); tr = sample_idx + 10; trig_q.push_back(tr);
    run(270, 100, 100);
    total++; if (out_cnt != 192 || tlast_cnt != 3) begin bad++; $display("FAIL multi count: got out=%0d tlast=%0d exp 192 3", out_cnt, tlast_cnt); end
    total++; if (sof_cnt != 1 || sof_pos != 1) begin bad++; $display("FAIL multi sof: got cnt=%0d pos=%0d exp 1 1", sof_cnt, sof_pos); end
    total++; if (eof_cnt != 1 || eof_pos != 192) begin bad++; $display("FAIL multi eof: got cnt=%0d pos=%0d exp 1 192", eof_cnt, eof_pos); end
  endtask

  task automatic test_keep_cp();
    int tr;
    configure(64, 16, 5, 2, 3);
    reset_stats(); tr = sample_idx + 10; trig_q.push_back(tr);
    run(200, 100, 100);
    total++; if (out_cnt != 160 || first_out != tr + 6 || last_out != tr + 165) begin bad++; $display("FAIL keep_cp range: got out=%0d %0d..%0d exp 160 %0d..%0d", out_cnt, first_out, last_out, tr + 6, tr + 165); end
    total++; if (tlast_cnt != 1 || eof_pos != 160 || sof_pos != 1) begin bad++; $display("FAIL keep_cp flags: got tlast=%0d eofpos=%0d sofpos=%0d exp 1 160 1", tlast_cnt, eof_pos, sof_pos); end
  endtask

  task automatic test_backpressure();
    int tr, mode, exp_out;
    for (int k = 0; k < 2; k++) begin
      mode = k * 2 + int'($urandom_range(1));
      exp_out = 4 * (64 + (((mode & 1) != 0) ? 16 : 0));
      configure(64, 16, 3, 4, mode);
      reset_stats(); tr = sample_idx + 5; trig_q.push_back(tr);
      run(2500, 70, 50);
      total++; if (out_cnt != exp_out || eof_cnt != 1) begin bad++; $display("FAIL backpressure count: got out=%0d eof=%0d exp %0d 1", out_cnt, eof_cnt, exp_out); end
      total++; if (last_out != tr + 323) begin bad++; $display("FAIL backpressure last: got %0d exp %0d", last_out, tr + 323); end
    end
  endtask

  task automatic test_ignored_triggers();
    int tr;
    step(0, 1, 1);
    configure(64, 16, 0, 2, 0);
    reset_stats(); tr = sample_idx + 5;
    trig_q.push_back(tr); trig_q.push_back(tr + 20); trig_q.push_back(tr + 90);
    trig_q.push_back(tr + 160); trig_q.push_back(tr + 200);
    run(50, 100, 100);
    write_set(0, 32);
    run(300, 100, 100);
    total++; if (trig_ignored !== 16'd3) begin bad++; $display("FAIL ignored count: got %0d exp 3", trig_ignored); end
    total++; if (out_cnt != 192 || tlast_cnt != 4 || eof_cnt != 2) begin bad++; $display("FAIL ignored frames: got out=%0d tlast=%0d eof=%0d exp 192 4 2", out_cnt, tlast_cnt, eof_cnt); end
    total++; if (last_out != tr + 296) begin bad++; $display("FAIL ignored last: got %0d exp %0d", last_out, tr + 296); end
  endtask

  task automatic test_clear_abort();
    int tr;
    configure(64, 16, 0, 3, 0);
    reset_stats(); tr = sample_idx + 5; trig_q.push_back(tr);
    run(126, 100, 100);
    step(0, 1, 1);
    tr = sample_idx + 5; trig_q.push_back(tr);
    run(260, 100, 100);
    total++; if (eof_cnt != 1 || sof_cnt != 2) begin bad++; $display("FAIL clear flags: got eof=%0d sof=%0d exp 1 2", eof_cnt, sof_cnt); end
    total++; if (out_cnt != 280 || tlast_cnt != 4) begin bad++; $display("FAIL clear count: got out=%0d tlast=%0d exp 280 4", out_cnt, tlast_cnt); end
    total++; if (last_out != tr + 240) begin bad++; $display("FAIL clear last: got %0d exp %0d", last_out, tr + 240); end
  endtask

  task automatic test_async_reset();
    int tr;
    trig_q.delete();
    tr = sample_idx + 3; trig_q.push_back(tr);
    run(30, 100, 100);
    i_tvalid = 1; o_tready = 1; i_trig = 0; clear = 0;
    #1;
    total++; if (o_tvalid !== 1'b1) begin bad++; $display("FAIL pre-reset o_tvalid: got %b exp 1", o_tvalid); end
    #1 rst = 1;
    #1;
    test_reset();
    @(posedge clk); #1 rst = 0;
    model_reset(); trig_q.delete();
    reset_stats(); tr = sample_idx + 4; trig_q.push_back(tr);
    run(100, 100, 100);
    total++; if (out_cnt != 64 || first_out != tr + 17 || eof_cnt != 1) begin bad++; $display("FAIL post-reset defaults: got out=%0d first=%0d eof=%0d exp 64 %0d 1", out_cnt, first_out, eof_cnt, tr + 17); end
  endtask

  task automatic test_zero_settings();
    int tr;
    configure(0, 0, 0, 0, 0);
    reset_stats(); tr = sample_idx + 3; trig_q.push_back(tr);
    run(12, 100, 100);
    total++; if (out_cnt != 1 || first_out != tr + 1 || tlast_cnt != 1 || sof_cnt != 1 || eof_cnt != 1) begin bad++; $display("FAIL zero settings: got out=%0d first=%0d tlast=%0d sof=%0d eof=%0d exp 1 %0d 1 1 1", out_cnt, first_out, tlast_cnt, sof_cnt, eof_cnt, tr + 1); end
  endtask

  initial begin
    rst = 1; clear = 0; set_stb = 0; set_addr = '0; set_data = '0;
    i_tdata = '0; i_tlast = 0; i_tvalid = 0; i_trig = 0; o_tready = 1;
    sample_idx = 0; model_reset(); reset_stats();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 0;
    test_single_frame();
    test_multi_symbol();
    test_keep_cp();
    test_backpressure();
    test_ignored_triggers();
    test_clear_abort();
    test_async_reset();
    test_zero_settings();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
